hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage IF/ID/EX/MEM/WB core.
//  - Detects RAW and load-use hazards and drives stall/bubble to PC, if_id and id_ex.
//  - Flushes wrong-path instructions on a taken branch or jump.
//  - Sequences the halt drain and resume.
//  - Drives EX operand forwarding selects and keeps stall/flush statistics for the display path.

---
 rtl/hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard / flush / halt sequencing controller for the 5-stage core.
// Latency: stall, flush, bubble and forward selects are combinational in the current cycle; halted and the counters are registered.
// Backpressure: this block is the backpressure source. It holds PC and if_id and bubbles id_ex while a hazard, drain or halt is active.
//
// Ports:
//   clk, RST              clock (rising edge) and asynchronous active-low reset
//   id_rs/id_rt/id_use_*  source registers of the ID instruction, and whether each is read
//   id_halt               ID instruction is a syscall-halt
//   ex_rs/ex_rt/ex_rw     EX sources and destination; ex_regwrite, ex_memtoreg (load)
//   mem_rw/mem_regwrite   MEM destination
//   wb_rw/wb_regwrite     WB destination
//   ex_redirect           EX resolved a taken branch or jump
//   resume                single-cycle pulse that leaves the HALTED state
//   pc_stall/ifid_stall   hold PC / hold if_id
//   ifid_flush            load a NOP into if_id
//   idex_bubble           load a NOP (all controls 0) into id_ex
//   fwd_a/fwd_b           EX operand select: 00 regfile, 01 MEM ALU, 10 WB result
//   halted                core halted (registered)
//   stall_cnt/flush_cnt   saturating statistics for hazard-stall cycles and redirect flushes
//
// Build option: define FORWARD_EN to enable EX operand forwarding. With forwarding on,
// only load-use hazards stall. Without it, any EX/MEM producer of a used source stalls.
module hazard_ctrl #(
    parameter int CNT_W      = 32,
    parameter int HALT_DRAIN = 3
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_halt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rw,
    input  logic             ex_regwrite,
    input  logic             ex_memtoreg,
    input  logic [4:0]       mem_rw,
    input  logic             mem_regwrite,
    input  logic [4:0]       wb_rw,
    input  logic             wb_regwrite,
    input  logic             ex_redirect,
    input  logic             resume,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW = (HALT_DRAIN < 2) ? 1 : $clog2(HALT_DRAIN + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t          state;
    logic [DW-1:0]   drain_cnt;

    // A producer matches a source only if it writes a register and it is not $0.
    function automatic logic match(input logic we, input logic [4:0] rw, input logic [4:0] r);
        return we && (rw == r) && (r != 5'd0);
    endfunction

    logic hit_ex;
    logic hit_mem;
    logic hazard;

    assign hit_ex  = (id_use_rs && match(ex_regwrite, ex_rw, id_rs)) ||
                     (id_use_rt && match(ex_regwrite, ex_rw, id_rt));
    assign hit_mem = (id_use_rs && match(mem_regwrite, mem_rw, id_rs)) ||
                     (id_use_rt && match(mem_regwrite, mem_rw, id_rt));

`ifdef FORWARD_EN
    // Forwarding covers every case except a load in EX, whose data is not ready yet.
    logic unused_mem_hit;
    assign unused_mem_hit = hit_mem;
    assign hazard         = ex_memtoreg && hit_ex;
`else
    // No forwarding: wait until the producer reaches WB. The regfile writes
    // in the first half-cycle, so a WB producer is already visible to ID.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ex_rs, ex_rt, wb_rw, wb_regwrite, ex_memtoreg};
    assign hazard            = hit_ex || hit_mem;
`endif

    // Per-cycle decisions. These are only meaningful in RUN, with priority
    // flush > hazard stall > halt entry.
    logic in_run;
    logic held;
    logic do_flush;
    logic do_stall;
    logic do_halt;

    assign in_run   = (state == ST_RUN);
    assign held     = (state != ST_RUN);
    assign do_flush = in_run && ex_redirect;
    assign do_stall = in_run && !ex_redirect && hazard;
    assign do_halt  = in_run && !ex_redirect && !hazard && id_halt;

    // Combinational outputs are forced low while reset is asserted.
    assign pc_stall    = RST && (do_stall || held);
    assign ifid_stall  = RST && (do_stall || held);
    assign ifid_flush  = RST && do_flush;
    assign idex_bubble = RST && (do_flush || do_stall || held);

`ifdef FORWARD_EN
    // MEM holds the newer value, so it wins over WB.
    function automatic logic [1:0] fwd_sel(input logic [4:0] r);
        if (match(mem_regwrite, mem_rw, r)) begin
            return 2'b01;
        end else if (match(wb_regwrite, wb_rw, r)) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    assign fwd_a = RST ? fwd_sel(ex_rs) : 2'b00;
    assign fwd_b = RST ? fwd_sel(ex_rt) : 2'b00;
`else
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

    // Halt FSM and statistics. The drain counter gives the halt instruction
    // time to travel EX/MEM/WB before the core reports itself halted.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            halted    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (do_stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (do_flush && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end

            case (state)
                ST_RUN: begin
                    if (do_halt) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DW'(HALT_DRAIN);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt <= DW'(1)) begin
                        state     <= ST_HALTED;
                        halted    <= 1'b1;
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                ST_HALTED: begin
                    if (resume) begin
                        state  <= ST_RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    halted    <= 1'b0;
                    drain_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, load-use / RAW stalls, forwarding,
// redirect flush, halt drain/resume, counter saturation and async reset.
// Expectations adapt to whether FORWARD_EN is defined for the build.
module tb_hazard_ctrl;

`ifdef FORWARD_EN
    localparam int FWD = 1;
`else
    localparam int FWD = 0;
`endif
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          RST;
    logic [4:0]    id_rs, id_rt, ex_rs, ex_rt, ex_rw, mem_rw, wb_rw;
    logic          id_use_rs, id_use_rt, id_halt;
    logic          ex_regwrite, ex_memtoreg, mem_regwrite, wb_regwrite;
    logic          ex_redirect, resume;
    logic          pc_stall, ifid_stall, ifid_flush, idex_bubble, halted;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    hazard_ctrl #(.CNT_W(CW), .HALT_DRAIN(3)) dut (
        .clk(clk), .RST(RST),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_halt(id_halt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rw(ex_rw),
        .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
        .mem_rw(mem_rw), .mem_regwrite(mem_regwrite),
        .wb_rw(wb_rw), .wb_regwrite(wb_regwrite),
        .ex_redirect(ex_redirect), .resume(resume),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_halt = 0;
        ex_rs = 0; ex_rt = 0; ex_rw = 0; ex_regwrite = 0; ex_memtoreg = 0;
        mem_rw = 0; mem_regwrite = 0; wb_rw = 0; wb_regwrite = 0;
        ex_redirect = 0; resume = 0;
    endtask

    // Advance one rising edge, then settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load in EX writing $5, ID reading $5: stalls in both build variants.
    task automatic load_use();
        idle();
        ex_regwrite = 1; ex_memtoreg = 1; ex_rw = 5;
        id_rs = 5; id_use_rs = 1;
    endtask

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    initial begin
        // Reset with hazard inputs active: combinational outputs must stay low.
        RST = 0;
        load_use();
        ex_redirect = 1; ex_rs = 2; mem_regwrite = 1; mem_rw = 2;
        #12;
        check("rst_pc_stall", pc_stall, 0);
        check("rst_flush", ifid_flush, 0);
        check("rst_bubble", idex_bubble, 0);
        check("rst_fwd_a", fwd_a, 0);
        check("rst_halted", halted, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        idle();
        @(negedge clk);
        RST = 1;
        tick();

        // lw $2 ; add $3,$2,$1
        idle();
        ex_regwrite = 1; ex_memtoreg = 1; ex_rw = 2;
        id_rs = 2; id_rt = 1; id_use_rs = 1; id_use_rt = 1;
        #1;
        check("t1a_pc_stall", pc_stall, 1);
        check("t1a_ifid_stall", ifid_stall, 1);
        check("t1a_bubble", idex_bubble, 1);
        check("t1a_flush", ifid_flush, 0);
        exp_stall = sat_inc(exp_stall);
        tick();
        // bubble in EX, lw in MEM, add still in ID
        ex_regwrite = 0; ex_memtoreg = 0; ex_rw = 0;
        mem_regwrite = 1; mem_rw = 2;
        #1;
        check("t1b_pc_stall", pc_stall, 1 - FWD);
        if (pc_stall == 1'b1 || FWD == 0) exp_stall = exp_stall + (1 - FWD);
        tick();
        // add in EX, lw in WB
        idle();
        ex_rs = 2; ex_rt = 1; ex_rw = 3; ex_regwrite = 1;
        wb_regwrite = 1; wb_rw = 2;
        #1;
        check("t1c_pc_stall", pc_stall, 0);
        check("t1c_fwd_a", fwd_a, FWD ? 2 : 0);
        check("t1c_fwd_b", fwd_b, 0);
        tick();
        check("t1_stall_cnt", stall_cnt, FWD ? 1 : 2);

        // add $2 ; sub $4,$2,$2
        idle();
        ex_regwrite = 1; ex_rw = 2;
        id_rs = 2; id_rt = 2; id_use_rs = 1; id_use_rt = 1;
        #1;
        check("t2a_pc_stall", pc_stall, 1 - FWD);
        exp_stall = exp_stall + (1 - FWD);
        tick();
        // sub in EX, add in MEM, an older $2 writer in WB (MEM must win)
        idle();
        ex_rs = 2; ex_rt = 2; ex_rw = 4; ex_regwrite = 1;
        mem_regwrite = 1; mem_rw = 2;
        wb_regwrite = 1; wb_rw = 2;
        #1;
        check("t2b_fwd_a", fwd_a, FWD ? 1 : 0);
        check("t2b_fwd_b", fwd_b, FWD ? 1 : 0);
        // $0 never forwards; WB only
        ex_rt = 0; mem_rw = 0;
        #1;
        check("t2c_fwd_a_wb", fwd_a, FWD ? 2 : 0);
        check("t2c_fwd_b_r0", fwd_b, 0);
        tick();
        check("t2_stall_cnt", stall_cnt, exp_stall);

        // $0 load and an unused source never stall
        idle();
        ex_regwrite = 1; ex_memtoreg = 1; ex_rw = 0; id_rs = 0; id_use_rs = 1;
        #1;
        check("r0_no_stall", pc_stall, 0);
        ex_rw = 7; id_rt = 7; id_use_rt = 0;
        #1;
        check("unused_src_no_stall", pc_stall, 0);
        tick();

        // Taken branch with halt and a hazard in ID: flush wins
        load_use();
        ex_redirect = 1; id_halt = 1;
        #1;
        check("t4_flush", ifid_flush, 1);
        check("t4_bubble", idex_bubble, 1);
        check("t4_pc_stall", pc_stall, 0);
        check("t4_ifid_stall", ifid_stall, 0);
        exp_flush = exp_flush + 1;
        tick();
        idle();
        #1;
        check("t4_still_run", pc_stall, 0);
        check("t4_flush_cnt", flush_cnt, exp_flush);
        check("t4_stall_cnt", stall_cnt, exp_stall);

        // Halt drain and resume
        id_halt = 1;
        #1;
        check("t5_entry_no_stall", pc_stall, 0);
        tick();                     // edge 0: enters DRAIN
        idle();
        resume = 1;                 // ignored while draining
        #1;
        check("t5_drain_stall", pc_stall, 1);
        check("t5_drain_bubble", idex_bubble, 1);
        tick();                     // edge 1
        resume = 0;
        ex_redirect = 1;            // ignored while draining
        #1;
        check("t5_drain_noflush", ifid_flush, 0);
        check("t5_e1_halted", halted, 0);
        tick();                     // edge 2
        ex_redirect = 0;
        check("t5_e2_halted", halted, 0);
        tick();                     // edge 3
        check("t5_e3_halted", halted, 1);
        load_use();
        ex_redirect = 1;
        #1;
        check("t5_halted_stall", pc_stall, 1);
        check("t5_halted_noflush", ifid_flush, 0);
        tick();
        check("t5_flush_cnt_hold", flush_cnt, exp_flush);
        check("t5_stall_cnt_hold", stall_cnt, exp_stall);
        check("t5_still_halted", halted, 1);
        idle();
        resume = 1;
        tick();
        resume = 0;
        #1;
        check("t5_resumed", halted, 0);
        check("t5_resumed_stall", pc_stall, 0);

        // Saturation of stall_cnt
        for (int i = 0; i < 20; i++) begin
            load_use();
            exp_stall = sat_inc(exp_stall);
            tick();
        end
        check("t6_sat", stall_cnt, exp_stall);
        check("t6_sat_max", stall_cnt, CMAX);
        load_use();
        tick();
        check("t6_sat_hold", stall_cnt, CMAX);

        // Async reset in the middle of a drain
        idle();
        id_halt = 1;
        tick();
        load_use();
        ex_redirect = 1; ex_rs = 2; mem_regwrite = 1; mem_rw = 2;
        #1;
        check("t6_in_drain", pc_stall, 1);
        RST = 0;
        #1;
        check("t6_rst_pc_stall", pc_stall, 0);
        check("t6_rst_ifid_stall", ifid_stall, 0);
        check("t6_rst_bubble", idex_bubble, 0);
        check("t6_rst_flush", ifid_flush, 0);
        check("t6_rst_fwd_a", fwd_a, 0);
        check("t6_rst_stall_cnt", stall_cnt, 0);
        check("t6_rst_flush_cnt", flush_cnt, 0);
        check("t6_rst_halted", halted, 0);
        idle();
        @(negedge clk);
        RST = 1;
        tick();
        tick();
        check("t6_post_rst_run", pc_stall, 0);
        check("t6_post_rst_halted", halted, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
